// File: rtl/spriteram_arbiter.sv
// Sprite RAM arbiter: engine reads, buffered CPU writes and single CPU readback share one 128x8 port.
// Optional SPRITERAM_VBLANK_COMMIT_EN: CPU writes commit to RAM only during vblank.
module spriteram_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vblank,
  input  logic [6:0] cpu_addr,
  input  logic [7:0] cpu_din,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  output logic [7:0] cpu_dout,
  output logic       cpu_rd_valid,
  output logic       cpu_busy,
  output logic       cpu_overflow,
  input  logic [6:0] se_addr,
  input  logic       se_req,
  output logic       se_gnt,
  output logic [7:0] se_dout,
  output logic       se_valid,
  output logic [6:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       ram_wr,
  input  logic [7:0] ram_dout
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SE, ARB_CPU_WR, ARB_CPU_RD} arb_e;

  arb_e            arb_q, arb_d;
  logic [14:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_pend_q, rd_pend_d;
  logic [6:0]      rd_addr_q;
  logic [7:0]      starve_q, starve_d;
  logic [6:0]      ram_addr_q;
  logic [7:0]      ram_din_q;
  logic            ram_wr_q;
  logic            se_valid_q, cpu_valid_q;
  logic [7:0]      se_hold_q, cpu_hold_q;
  logic            ovf_q;

  logic            fifo_empty, fifo_full, rd_busy, cpu_pend, starved;
  logic            force_op, wr_ok, push, pop, rd_take;
  logic [14:0]     head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  // A read stays outstanding from the strobe until the cycle its data returns.
  assign rd_busy    = rd_pend_q || (arb_q == ARB_CPU_RD);
  assign cpu_pend   = !fifo_empty || rd_pend_q;
  assign starved    = (starve_q >= 8'(STARVE_LIMIT));
  assign head       = fifo_q[rd_ptr_q];

`ifdef SPRITERAM_VBLANK_COMMIT_EN
  assign wr_ok    = vblank;
  assign force_op = starved && rd_pend_q && fifo_empty;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign wr_ok    = 1'b1;
  assign force_op = starved && cpu_pend;
`endif

  always_comb begin
    arb_d = ARB_IDLE;
    if (force_op)                     arb_d = fifo_empty ? ARB_CPU_RD : ARB_CPU_WR;
    else if (se_req)                  arb_d = ARB_SE;
    else if (rd_pend_q && fifo_empty) arb_d = ARB_CPU_RD;
    else if (!fifo_empty && wr_ok)    arb_d = ARB_CPU_WR;
  end

  assign pop     = (arb_d == ARB_CPU_WR);
  assign push    = cpu_wr && (!fifo_full || pop);
  assign rd_take = cpu_rd && !rd_busy;
  assign cnt_d   = cnt_q + CW'(push) - CW'(pop);

  always_comb begin
    starve_d  = starve_q;
    rd_pend_d = rd_pend_q;
    if (arb_d == ARB_CPU_WR || arb_d == ARB_CPU_RD) starve_d = '0;
    else if (cpu_pend && arb_d == ARB_SE && !starved) starve_d = starve_q + 8'd1;
    if (arb_d == ARB_CPU_RD) rd_pend_d = 1'b0;
    else if (rd_take)        rd_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {cpu_addr, cpu_din};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arb_q       <= ARB_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      starve_q    <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_wr_q    <= 1'b0;
      se_valid_q  <= 1'b0;
      cpu_valid_q <= 1'b0;
      se_hold_q   <= '0;
      cpu_hold_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      arb_q     <= arb_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      starve_q  <= starve_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (rd_take) rd_addr_q <= cpu_addr;
      if (cpu_wr && fifo_full && !pop) ovf_q <= 1'b1;
      ram_wr_q <= pop;
      case (arb_d)
        ARB_SE:     ram_addr_q <= se_addr;
        ARB_CPU_RD: ram_addr_q <= rd_addr_q;
        ARB_CPU_WR: begin
          ram_addr_q <= head[14:8];
          ram_din_q  <= head[7:0];
        end
        default: ;
      endcase
      // arb_q names the access the RAM is serving this cycle; its data lands next cycle.
      se_valid_q  <= (arb_q == ARB_SE);
      cpu_valid_q <= (arb_q == ARB_CPU_RD);
      if (se_valid_q)  se_hold_q  <= ram_dout;
      if (cpu_valid_q) cpu_hold_q <= ram_dout;
    end
  end

  assign se_gnt       = reset_n && (arb_d == ARB_SE);
  assign ram_addr     = ram_addr_q;
  assign ram_din      = ram_din_q;
  assign ram_wr       = ram_wr_q;
  assign se_valid     = se_valid_q;
  assign cpu_rd_valid = cpu_valid_q;
  assign se_dout      = se_valid_q ? ram_dout : se_hold_q;
  assign cpu_dout     = cpu_valid_q ? ram_dout : cpu_hold_q;
  assign cpu_busy     = fifo_full || rd_busy;
  assign cpu_overflow = ovf_q;
endmodule

// File: tb/tb_spriteram_arbiter.sv
// Bench for spriteram_arbiter: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_spriteram_arbiter;
  localparam int D   = 4;
  localparam int LIM = 8;

  logic       clk = 1'b0, reset_n = 1'b0, vblank = 1'b0;
  logic [6:0] cpu_addr = '0, se_addr = '0;
  logic [7:0] cpu_din = '0;
  logic       cpu_wr = 1'b0, cpu_rd = 1'b0, se_req = 1'b0;
  logic [7:0] cpu_dout, se_dout, ram_din, ram_dout;
  logic       cpu_rd_valid, cpu_busy, cpu_overflow, se_gnt, se_valid, ram_wr;
  logic [6:0] ram_addr;

  logic       pre_en = 1'b0;
  logic [6:0] pre_a = '0;
  logic [7:0] pre_d = '0;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  spriteram_arbiter #(.FIFO_DEPTH(D), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n), .vblank(vblank),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_dout(cpu_dout), .cpu_rd_valid(cpu_rd_valid), .cpu_busy(cpu_busy),
    .cpu_overflow(cpu_overflow), .se_addr(se_addr), .se_req(se_req), .se_gnt(se_gnt),
    .se_dout(se_dout), .se_valid(se_valid), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_wr(ram_wr), .ram_dout(ram_dout));

  // Sprite RAM with registered read port.
  logic [7:0] ram_mem [128];
  always @(posedge clk) begin
    if (pre_en) ram_mem[pre_a] <= pre_d;
    else if (ram_wr) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, memory image updated in grant order.
  logic [14:0] mq[$];
  logic [7:0]  mmem [128];
  bit          m_rdp, m_ovf, e_wr, e_sv, e_cv;
  logic [6:0]  m_rda, e_addr;
  logic [7:0]  e_din, e_sd, e_cd, s_stage, c_stage;
  int          m_starve, m_last, win;   // 0 none, 1 engine, 2 cpu write, 3 cpu read

  always @(negedge clk) begin
    bit pend, force_it, wr_allow, rd_acc;
    logic [14:0] ent;
    if (pre_en) mmem[pre_a] = pre_d;
    if (!reset_n) begin
      chk("rst_ram_wr", 32'(ram_wr), 0);      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_din", 32'(ram_din), 0);    chk("rst_se_gnt", 32'(se_gnt), 0);
      chk("rst_se_valid", 32'(se_valid), 0);  chk("rst_se_dout", 32'(se_dout), 0);
      chk("rst_cpu_dout", 32'(cpu_dout), 0);  chk("rst_cpu_valid", 32'(cpu_rd_valid), 0);
      chk("rst_overflow", 32'(cpu_overflow), 0); chk("rst_busy", 32'(cpu_busy), 0);
      mq.delete(); m_rdp = 0; m_ovf = 0; m_starve = 0; m_last = 0;
      e_wr = 0; e_sv = 0; e_cv = 0;
    end else begin
      chk("ram_wr", 32'(ram_wr), 32'(e_wr));
      if (m_last != 0) chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_wr) chk("ram_din", 32'(ram_din), 32'(e_din));
      chk("se_valid", 32'(se_valid), 32'(e_sv));
      if (e_sv) chk("se_dout", 32'(se_dout), 32'(e_sd));
      chk("cpu_rd_valid", 32'(cpu_rd_valid), 32'(e_cv));
      if (e_cv) chk("cpu_dout", 32'(cpu_dout), 32'(e_cd));
      chk("cpu_busy", 32'(cpu_busy), 32'((mq.size() == D) || m_rdp || (m_last == 3)));
      chk("cpu_overflow", 32'(cpu_overflow), 32'(m_ovf));

      pend = (mq.size() > 0) || m_rdp;
`ifdef SPRITERAM_VBLANK_COMMIT_EN
      force_it = m_rdp && mq.size() == 0 && m_starve >= LIM;
      wr_allow = vblank;
`else
      force_it = pend && m_starve >= LIM;
      wr_allow = 1;
`endif
      if (force_it)                      win = (mq.size() == 0) ? 3 : 2;
      else if (se_req)                   win = 1;
      else if (m_rdp && mq.size() == 0)  win = 3;
      else if (mq.size() > 0 && wr_allow) win = 2;
      else                               win = 0;
      chk("se_gnt", 32'(se_gnt), 32'(win == 1));

      e_sv = (m_last == 1); e_sd = s_stage;
      e_cv = (m_last == 3); e_cd = c_stage;
      e_wr = (win == 2);
      rd_acc = cpu_rd && !m_rdp && (m_last != 3);
      case (win)
        1: begin s_stage = mmem[se_addr]; e_addr = se_addr; end
        2: begin
          ent = mq.pop_front();
          mmem[ent[14:8]] = ent[7:0];
          e_addr = ent[14:8]; e_din = ent[7:0];
        end
        3: begin c_stage = mmem[m_rda]; e_addr = m_rda; m_rdp = 0; end
        default: ;
      endcase
      if (win == 2 || win == 3) m_starve = 0;
      else if (win == 1 && pend && m_starve < LIM) m_starve++;
      if (cpu_wr) begin
        if (mq.size() < D) mq.push_back({cpu_addr, cpu_din});
        else m_ovf = 1;
      end
      if (rd_acc) begin m_rdp = 1; m_rda = cpu_addr; end
      m_last = win;
    end
  end

  // Log of RAM writes and busy cycles for the directed scenarios.
  logic [6:0] wl_a[$];
  logic [7:0] wl_d[$];
  int         wl_t[$];
  int         cyc = 0, busy_cnt = 0;
  always @(negedge clk) begin
    cyc++;
    if (reset_n && ram_wr) begin wl_a.push_back(ram_addr); wl_d.push_back(ram_din); wl_t.push_back(cyc); end
    if (reset_n && cpu_busy) busy_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int n0, b0, n, pct_se;
    bit got, g, hit34;
    for (int a = 0; a < 128; a++) begin
      pre_en = 1; pre_a = 7'(a); pre_d = 8'(a) ^ 8'h5A; tick();
    end
    pre_a = 7'h04; pre_d = 8'h9A; tick();
    pre_a = 7'h20; pre_d = 8'h11; tick();
    pre_en = 0; tick();
    reset_n = 1; tick();

    // Engine read: grant in the request cycle, data two edges later.
    se_addr = 7'h04; se_req = 1;
    @(negedge clk) chk("eng_gnt", 32'(se_gnt), 1);
    tick(); se_req = 0;
    @(negedge clk) chk("eng_valid_early", 32'(se_valid), 0);
    tick();
    @(negedge clk) begin chk("eng_valid", 32'(se_valid), 1); chk("eng_data", 32'(se_dout), 32'h9A); end
    tick();

    // CPU write burst with idle engine.
    n0 = wl_a.size(); b0 = busy_cnt;
    for (int i = 0; i < 4; i++) begin
      cpu_wr = 1; cpu_addr = 7'(8'h10 + i); cpu_din = 8'(8'hA0 + i); tick();
    end
    cpu_wr = 0;
    repeat (8) tick();
    chk("burst_count", 32'(wl_a.size() - n0), 4);
    for (int i = 0; i < 4; i++) if (wl_a.size() > n0 + i) begin
      chk("burst_addr", 32'(wl_a[n0+i]), 32'(8'h10 + i));
      chk("burst_data", 32'(wl_d[n0+i]), 32'(8'hA0 + i));
      chk("burst_consec", 32'(wl_t[n0+i] - wl_t[n0]), 32'(i));
    end
    chk("burst_busy", 32'(busy_cnt - b0), 0);

    // Overflow while the engine hogs the port.
    se_req = 1; se_addr = 7'h07;
    n0 = wl_a.size();
    for (int i = 0; i < 5; i++) begin
      cpu_wr = 1; cpu_addr = 7'(8'h30 + i); cpu_din = 8'(8'hB0 + i); tick();
      if (i == 3) @(negedge clk) chk("ovf_busy_full", 32'(cpu_busy), 1);
      if (i == 4) @(negedge clk) chk("ovf_sticky", 32'(cpu_overflow), 1);
    end
    cpu_wr = 0;
    for (int k = 0; k < 200 && (wl_a.size() - n0) < 4; k++) tick();
    repeat (20) tick();
    chk("ovf_commit_count", 32'(wl_a.size() - n0), 4);
    hit34 = 0;
    for (int i = n0; i < wl_a.size(); i++) if (wl_a[i] == 7'h34 || wl_d[i] == 8'hB4) hit34 = 1;
    chk("ovf_dropped_absent", 32'(hit34), 0);
    for (int i = 0; i < 4; i++) if (wl_a.size() > n0 + i) begin
      chk("ovf_addr", 32'(wl_a[n0+i]), 32'(8'h30 + i));
      chk("ovf_data", 32'(wl_d[n0+i]), 32'(8'hB0 + i));
    end

    // Reset with queued writes and a pending read.
    for (int i = 0; i < 3; i++) begin
      cpu_wr = 1; cpu_addr = 7'(8'h40 + i); cpu_din = 8'(8'hD0 + i); tick();
    end
    cpu_wr = 0; cpu_rd = 1; cpu_addr = 7'h40; tick();
    cpu_rd = 0;
    @(negedge clk) chk("mid_busy_before", 32'(cpu_busy), 1);
    @(posedge clk); #2 reset_n = 0;
    #1;
    chk("mid_ram_wr", 32'(ram_wr), 0);   chk("mid_ram_addr", 32'(ram_addr), 0);
    chk("mid_se_gnt", 32'(se_gnt), 0);   chk("mid_se_valid", 32'(se_valid), 0);
    chk("mid_busy", 32'(cpu_busy), 0);   chk("mid_overflow", 32'(cpu_overflow), 0);
    chk("mid_cpu_valid", 32'(cpu_rd_valid), 0);
    se_req = 0;
    tick(); reset_n = 1;
    n0 = wl_a.size();
    repeat (10) tick();
    chk("mid_no_stale_wr", 32'(wl_a.size() - n0), 0);
    chk("mid_ovf_clear", 32'(cpu_overflow), 0);

    // Starvation: exactly LIM engine grants, then one forced CPU write.
    se_req = 1; se_addr = 7'h09;
    tick(); tick();
    cpu_wr = 1; cpu_addr = 7'h50; cpu_din = 8'hC5; tick();
    cpu_wr = 0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk) g = se_gnt;
      if (!g) break;
      n++;
    end
    chk("starve_gnts", 32'(n), LIM);
    @(negedge clk) begin
      chk("starve_ram_wr", 32'(ram_wr), 1);
      chk("starve_ram_addr", 32'(ram_addr), 32'h50);
      chk("starve_resume", 32'(se_gnt), 1);
    end
    tick();

    // Read-after-write in the same cycle under engine pressure.
    cpu_wr = 1; cpu_rd = 1; cpu_addr = 7'h20; cpu_din = 8'h55; tick();
    cpu_wr = 0; cpu_rd = 0;
    got = 0;
    for (int k = 0; k < 80 && !got; k++) begin
      @(negedge clk) if (cpu_rd_valid) begin got = 1; chk("raw_data", 32'(cpu_dout), 32'h55); end
    end
    chk("raw_returned", 32'(got), 1);
    se_req = 0; tick();

    // Random traffic in segments of varying engine load.
    for (int seg = 0; seg < 4; seg++) begin
      pct_se = (seg == 0) ? 0 : (seg == 1) ? 30 : (seg == 2) ? 70 : 100;
      for (int c = 0; c < 800; c++) begin
        @(negedge clk) g = se_gnt;
        @(posedge clk); #1;
        if (!se_req || g) begin
          se_req = ($urandom_range(0, 99) < pct_se);
          se_addr = 7'($urandom);
        end
        cpu_wr = ($urandom_range(0, 99) < 25);
        cpu_rd = ($urandom_range(0, 99) < 10);
        cpu_addr = 7'($urandom_range(0, 15));
        cpu_din = 8'($urandom);
        if ($urandom_range(0, 31) == 0) vblank = ~vblank;
      end
    end
    cpu_wr = 0; cpu_rd = 0; se_req = 0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
